// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - 16-bit output driver with static on/off or shared 8-bit PWM gating per bit
//
// Parameter:
//   PRESCALE     clk cycles per PWM counter step (>=1); period = 256*PRESCALE clks
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en_out_lo/hi output enable, bits 7:0 / 15:8
//   en_pwm_lo/hi PWM mode select, bits 7:0 / 15:8
//   duty         PWM duty cycle, latched at each period start
//   out          registered chip outputs
//   pwm_sync     one-clk pulse on the first cycle of each PWM period

module pwm_peripheral #(
   parameter int PRESCALE = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  en_out_lo,
   input  logic [7:0]  en_out_hi,
   input  logic [7:0]  en_pwm_lo,
   input  logic [7:0]  en_pwm_hi,
   input  logic [7:0]  duty,
   output logic [15:0] out,
   output logic        pwm_sync
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pre;
   logic [7:0]    cnt;
   logic [7:0]    duty_sh;
   logic          tick;
   logic          wrap;
   logic          pwm_sig;
   logic [15:0]   en;
   logic [15:0]   pm;

   assign tick = (pre == PRE_LAST);
   // Last step of the period: cnt rolls over to 0 on this edge.
   assign wrap = tick && (cnt == 8'hFF);

   // Full scale is forced high so 0xFF has no one-step dropout at cnt==255.
   assign pwm_sig = (duty_sh == 8'hFF) ? 1'b1 : (cnt < duty_sh);

   assign en = {en_out_hi, en_out_lo};
   assign pm = {en_pwm_hi, en_pwm_lo};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre      <= '0;
         cnt      <= 8'h00;
         duty_sh  <= 8'h00;
         out      <= 16'h0000;
         pwm_sync <= 1'b0;
      end else begin
         pre <= tick ? '0 : pre + 1'b1;
         if (tick) begin
            cnt <= cnt + 8'd1;
         end
         // Shadow only updates at the period boundary so pulses are never truncated.
         if (wrap) begin
            duty_sh <= duty;
         end
         // Enable dominates; PWM-mode bits follow the waveform, others are static high.
         out <= en & (~pm | {16{pwm_sig}});
         // Raised on the edge that makes cnt==0 and pre==0, so it is high exactly in that cycle.
         pwm_sync <= wrap;
      end
   end

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb/tb_pwm_peripheral.sv - directed self-checking bench for pwm_peripheral

module tb_pwm_peripheral;

   localparam int PERIOD = 3072;

   logic        clk;
   logic        rst_n;
   logic [7:0]  en_out_lo;
   logic [7:0]  en_out_hi;
   logic [7:0]  en_pwm_lo;
   logic [7:0]  en_pwm_hi;
   logic [7:0]  duty;
   logic [15:0] out;
   logic        pwm_sync;

   int checks = 0;
   int passed = 0;

   int highs;
   int trans;
   int sync_at;
   int sync_cnt;
   logic [7:0] hi_or;
   int nz;
   bit found;

   pwm_peripheral #(.PRESCALE(12)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_out_lo (en_out_lo),
      .en_out_hi (en_out_hi),
      .en_pwm_lo (en_pwm_lo),
      .en_pwm_hi (en_pwm_hi),
      .duty      (duty),
      .out       (out),
      .pwm_sync  (pwm_sync)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Samples one full period at negedges; the window ends on the next pwm_sync cycle.
   // Sample i reflects the counter state of cycle i-1 of the period (out lags cnt by one clk).
   task automatic measure_period(input int upd_idx, input logic [7:0] upd_val,
                                 output int h, output int t, output int s_at,
                                 output int s_cnt, output logic [7:0] h_or);
      logic prev;
      h = 0; t = 0; s_at = -1; s_cnt = 0; h_or = 8'h00; prev = 1'b0;
      for (int i = 1; i <= PERIOD; i++) begin
         @(negedge clk);
         if (out[0] === 1'b1) h++;
         if (i > 1 && out[0] !== prev) t++;
         prev = out[0];
         h_or = h_or | out[15:8];
         if (pwm_sync === 1'b1) begin
            s_cnt++;
            s_at = i;
         end
         if (i == upd_idx) duty = upd_val;
      end
   endtask

   task automatic check_period(input string tag, input int exp_high, input int exp_trans);
      measure_period(0, 8'h00, highs, trans, sync_at, sync_cnt, hi_or);
      check({tag, "_high"}, highs, exp_high);
      check({tag, "_edges"}, trans, exp_trans);
      check({tag, "_sync_at"}, sync_at, PERIOD);
      check({tag, "_sync_cnt"}, sync_cnt, 1);
      check({tag, "_hi_gated"}, {24'h0, hi_or}, 32'h0);
   endtask

   initial begin
      rst_n     = 1'b0;
      en_out_lo = 8'hFF;
      en_out_hi = 8'hFF;
      en_pwm_lo = 8'hFF;
      en_pwm_hi = 8'hFF;
      duty      = 8'hFF;

      repeat (4) @(negedge clk);
      check("reset_out", out, 16'h0000);
      check("reset_sync", pwm_sync, 1'b0);

      // First period after release runs with duty_sh==0, so every PWM bit stays low.
      rst_n = 1'b1;
      nz = 0;
      sync_at = -1;
      for (int i = 1; i <= PERIOD; i++) begin
         @(negedge clk);
         if (out !== 16'h0000) nz++;
         if (pwm_sync === 1'b1 && sync_at < 0) sync_at = i;
      end
      check("first_period_low", nz, 0);
      check("first_sync_at", sync_at, PERIOD);
      @(negedge clk);
      check("first_ff_period", out, 16'hFFFF);
      check("sync_one_clk", pwm_sync, 1'b0);

      // Static drive, one clk latency.
      en_pwm_lo = 8'h00;
      en_pwm_hi = 8'h00;
      en_out_lo = 8'h01;
      en_out_hi = 8'h80;
      @(negedge clk);
      check("static_8001", out, 16'h8001);
      en_out_lo = 8'h00;
      @(negedge clk);
      check("static_8000", out, 16'h8000);

      // PWM-mode bits with enable off must stay low on the high byte.
      en_out_lo = 8'h01;
      en_out_hi = 8'h00;
      en_pwm_lo = 8'h01;
      en_pwm_hi = 8'hFF;
      duty      = 8'h80;
      @(negedge clk);
      check("gate_hi_static", out[15:8], 8'h00);

      found = 1'b0;
      for (int i = 0; i < PERIOD + 16; i++) begin
         @(negedge clk);
         if (pwm_sync === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      check("sync_found", found, 1'b1);

      // 50%: 128 steps * 12 clks high.
      check_period("d80_p1", 1536, 1);
      check_period("d80_p2", 1536, 1);

      // Duty 0x00: one more 0x80 period, then constant low.
      duty = 8'h00;
      check_period("d80_tail", 1536, 1);
      check_period("d00_p1", 0, 0);
      check_period("d00_p2", 0, 0);

      // Duty 0xFF: constant high with no dropout at cnt==255.
      duty = 8'hFF;
      check_period("d00_tail", 0, 0);
      check_period("dff_p1", PERIOD, 0);
      check_period("dff_p2", PERIOD, 0);

      // Mid-period update: 0x40 active, 0xC0 written at cnt==0x10 (cycle 192 of period).
      duty = 8'h40;
      check_period("dff_tail", PERIOD, 0);
      measure_period(192, 8'hC0, highs, trans, sync_at, sync_cnt, hi_or);
      check("d40_upd_high", highs, 768);
      check("d40_upd_edges", trans, 1);
      check("d40_upd_sync_at", sync_at, PERIOD);
      check_period("dc0_next", 2304, 1);

      // Asynchronous reset in the middle of a high phase.
      en_out_lo = 8'hFF;
      en_pwm_lo = 8'h01;
      repeat (100) @(negedge clk);
      check("pre_reset_high", out[0], 1'b1);
      check("pre_reset_static", out[7:1], 7'h7F);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_out", out, 16'h0000);
      check("async_reset_sync", pwm_sync, 1'b0);
      @(negedge clk);
      check("reset_hold_out", out, 16'h0000);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
